pipe_flush_ctrl: RTL



---
 rtl/pipe_flush_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_flush_ctrl.sv
// Turns a resolved taken jump into per-stage synchronous-clear strobes, held for FLUSH_CYCLES cycles.
// Latency: jump sampled at edge N asserts flush in cycle N+1; all outputs are registered.
// Backpressure: bus_stall defers a requested flush (PEND) and freezes an active one.
module pipe_flush_ctrl #(
    parameter int                    NUM_STAGES   = 4,
    parameter logic [NUM_STAGES-1:0] FLUSH_MASK   = 4'b0011,
    parameter int                    FLUSH_CYCLES = 1,
    parameter int                    CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_jump,
    input  logic                  pc_jump_control,
    input  logic                  bus_stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  busy,
    output logic                  pending,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int               REM_W  = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [REM_W-1:0] REM_LD = REM_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [REM_W-1:0] remain;
    logic             jump_req;
    logic             start_flush;

    assign jump_req = enable_jump & pc_jump_control;

    // Entry into FLUSH from either waiting state; this is what the event counter tallies.
    assign start_flush = ((state == S_IDLE) & jump_req & ~bus_stall) |
                         ((state == S_PEND) & ~bus_stall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            remain      <= '0;
            flush       <= '0;
            busy        <= 1'b0;
            pending     <= 1'b0;
            flush_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (jump_req && bus_stall) begin
                        state   <= S_PEND;
                        busy    <= 1'b1;
                        pending <= 1'b1;
                    end else if (jump_req) begin
                        state  <= S_FLUSH;
                        remain <= REM_LD;
                        flush  <= FLUSH_MASK;
                        busy   <= 1'b1;
                    end
                end
                S_PEND: begin
                    // Further jumps here come from younger instructions that this flush will kill.
                    if (!bus_stall) begin
                        state   <= S_FLUSH;
                        remain  <= REM_LD;
                        flush   <= FLUSH_MASK;
                        pending <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (!bus_stall) begin
                        if (remain != '0) begin
                            remain <= remain - 1'b1;
                        end else begin
                            state <= S_IDLE;
                            flush <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    remain  <= '0;
                    flush   <= '0;
                    busy    <= 1'b0;
                    pending <= 1'b0;
                end
            endcase

            if (start_flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
